sfifo_prog: RTL

Parametrised synchronous FIFO, the successor to the current single-mode sync FIFO. It adds:
- non-power-of-2 depth,
- a configurable read-data pipeline delay with a valid strobe,
- programmable almost-full/almost-empty thresholds,
- single-cycle overflow/underflow pulses, and a flush.

It sits between a producer and a consumer in one clock domain and is the FIFO driven by the UVM FIFO bench via its dut interface.

---
 rtl/sfifo_pkg.sv | 25 ++
 rtl/sfifo_dly_pipe.sv | 51 +++++
 rtl/sfifo_prog.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_pkg
// Description : Shared constants, types and helpers for the programmable
//               synchronous FIFO (sfifo_prog) and its read-delay pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package sfifo_pkg;

    // Upper bound on extra read-data register stages
    localparam int SFIFO_DLY_MAX = 4;

    // Operating mode, used for reporting only
    typedef enum logic [0:0] {
        STD  = 1'b0,
        FWFT = 1'b1
    } sfifo_mode_e;

    // Address width that never collapses to zero for tiny depths
    function automatic int sfifo_clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfifo_dly_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_dly_pipe
// Description : Read-data / valid delay line. One fixed output register plus
//               DLY extra stages. Data only advances alongside a valid, so the
//               output holds its last value while valid is low. Flush clears
//               every valid stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sfifo_dly_pipe #(
    parameter int DATA_W = 32,
    parameter int DLY    = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_flush,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    logic [DLY:0]      r_vld;
    logic [DATA_W-1:0] r_data [DLY+1];

    // Shift valid/data down the chain; flush kills all in-flight valids
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            for (int i = 0; i <= DLY; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld & ~i_flush;
            if (i_vld && !i_flush) begin
                r_data[0] <= i_data;
            end
            for (int i = 1; i <= DLY; i++) begin
                r_vld[i] <= r_vld[i-1] & ~i_flush;
                if (r_vld[i-1] && !i_flush) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign o_vld  = r_vld[DLY];
    assign o_data = r_data[DLY];

endmodule
`default_nettype wire

// File: rtl/sfifo_prog.sv
`default_nettype none
// ============================================================================
// Module      : sfifo_prog
// Description : Synchronous FIFO with arbitrary depth (>= 2), configurable
//               read latency with valid strobe, programmable almost-full /
//               almost-empty thresholds, overflow/underflow pulses and flush.
//               Optional macro SFIFO_FWFT_EN selects first-word fall-through
//               (head word shown whenever not empty, FIFO_DLY ignored).
// Revision    : 1.0 - initial release
// ============================================================================
module sfifo_prog
    import sfifo_pkg::*;
#(
    parameter int FIFO_D   = 12,
    parameter int FIFO_W   = 32,
    parameter int FIFO_DLY = 0,
    parameter int FIFO_ADR = sfifo_clog2(FIFO_D)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                fifo_we,
    input  logic [FIFO_W-1:0]   fifo_wd,
    output logic                fifo_full,
    output logic                fifo_afull,
    output logic                fifo_ovf,
    input  logic                fifo_re,
    output logic [FIFO_W-1:0]   fifo_rd,
    output logic                fifo_rvld,
    output logic                fifo_empt,
    output logic                fifo_aempt,
    output logic                fifo_udf,
    output logic [FIFO_ADR:0]   fifo_len,
    input  logic                fifo_fsh,
    input  logic [FIFO_ADR:0]   cfg_afull_th,
    input  logic [FIFO_ADR:0]   cfg_aempt_th
);

    localparam logic [FIFO_ADR:0]   c_len_full = (FIFO_ADR+1)'(FIFO_D);
    localparam logic [FIFO_ADR:0]   c_len_one  = (FIFO_ADR+1)'(1);
    localparam logic [FIFO_ADR-1:0] c_ptr_last = FIFO_ADR'(FIFO_D - 1);
    localparam logic [FIFO_ADR-1:0] c_ptr_one  = FIFO_ADR'(1);
    localparam int c_dly_eff = (FIFO_DLY > SFIFO_DLY_MAX) ? SFIFO_DLY_MAX : FIFO_DLY;

    logic [FIFO_W-1:0]   r_mem [FIFO_D];
    logic [FIFO_ADR-1:0] r_wptr;
    logic [FIFO_ADR-1:0] r_rptr;
    logic [FIFO_ADR:0]   r_len;
    logic [FIFO_ADR:0]   r_afull_th;
    logic [FIFO_ADR:0]   r_aempt_th;
    logic                r_ovf;
    logic                r_udf;

    logic                w_full;
    logic                w_empt;
    logic                w_push;
    logic                w_pop;
    logic                w_ovf;
    logic                w_udf;
    logic [FIFO_ADR-1:0] w_wptr_nxt;
    logic [FIFO_ADR-1:0] w_rptr_nxt;

    // Status decoded purely from registered state
    assign w_full = (r_len == c_len_full);
    assign w_empt = (r_len == '0);

    // Acceptance: flush masks everything; a pop frees room for a push when full
    assign w_pop  = fifo_re && !w_empt && !fifo_fsh;
    assign w_push = fifo_we && (!w_full || w_pop) && !fifo_fsh;
    assign w_ovf  = fifo_we && !w_push && !fifo_fsh;
    assign w_udf  = fifo_re && w_empt && !fifo_fsh;

    // Modulo-depth pointer increment
    assign w_wptr_nxt = (r_wptr == c_ptr_last) ? '0 : r_wptr + c_ptr_one;
    assign w_rptr_nxt = (r_rptr == c_ptr_last) ? '0 : r_rptr + c_ptr_one;

    // Storage array; contents need no reset since len gates visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= fifo_wd;
        end
    end

    // Pointers, occupancy, error pulses and threshold capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_len      <= '0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_afull_th <= '0;
            r_aempt_th <= '0;
        end else begin
            r_ovf      <= w_ovf;
            r_udf      <= w_udf;
            r_afull_th <= cfg_afull_th;
            r_aempt_th <= cfg_aempt_th;
            if (fifo_fsh) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_len  <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= w_wptr_nxt;
                end
                if (w_pop) begin
                    r_rptr <= w_rptr_nxt;
                end
                if (w_push && !w_pop) begin
                    r_len <= r_len + c_len_one;
                end else if (w_pop && !w_push) begin
                    r_len <= r_len - c_len_one;
                end
            end
        end
    end

    assign fifo_full  = w_full;
    assign fifo_empt  = w_empt;
    assign fifo_afull = (r_afull_th != '0) && (r_len >= r_afull_th);
    assign fifo_aempt = (r_len <= r_aempt_th);
    assign fifo_ovf   = r_ovf;
    assign fifo_udf   = r_udf;
    assign fifo_len   = r_len;

`ifdef SFIFO_FWFT_EN
    // Head word is presented directly; zero while empty keeps reset state clean
    assign fifo_rd   = w_empt ? '0 : r_mem[r_rptr];
    assign fifo_rvld = !w_empt;
`else
    logic              r_rd_vld;
    logic [FIFO_W-1:0] r_rd_data;

    // Array read register: captures the head word on the accepting edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= w_pop;
            if (w_pop) begin
                r_rd_data <= r_mem[r_rptr];
            end
        end
    end

    sfifo_dly_pipe #(
        .DATA_W (FIFO_W),
        .DLY    (c_dly_eff)
    ) u_dly_pipe (
        .clk     (clk),
        .rstn    (rstn),
        .i_flush (fifo_fsh),
        .i_vld   (r_rd_vld),
        .i_data  (r_rd_data),
        .o_vld   (fifo_rvld),
        .o_data  (fifo_rd)
    );
`endif

endmodule
`default_nettype wire
